gerador_vga: RTL and testbench

GERADOR_VGA -- requirements
Module: gerador_vga

---
 rtl/gerador_vga.sv | 72 +++++++
 tb/tb_gerador_vga.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/gerador_vga.sv
// VGA timing generator: free-running pixel/line counters gated by a
// pixel-clock enable, with sync, visible-area and end-of-line/frame decode.
module gerador_vga #(
  parameter int H_ATIVO = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_ATIVO = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       habilita,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_ativo,
  output logic       hsync,
  output logic       vsync,
  output logic       fim_linha,
  output logic       fim_quadro
);

  localparam int H_TOTAL = H_ATIVO + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ATIVO + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ATIVO);
  localparam logic [9:0] V_VIS    = 10'(V_ATIVO);
  localparam logic [9:0] HS_INI   = 10'(H_ATIVO + H_FP);
  localparam logic [9:0] HS_FIM   = 10'(H_ATIVO + H_FP + H_SYNC);
  localparam logic [9:0] VS_INI   = 10'(V_ATIVO + V_FP);
  localparam logic [9:0] VS_FIM   = 10'(V_ATIVO + V_FP + V_SYNC);

  logic [9:0] hcont;
  logic [9:0] vcont;
  logic       h_ultimo;
  logic       v_ultimo;

  assign h_ultimo = (hcont == H_MAX);
  assign v_ultimo = (vcont == V_MAX);

  // Counter advance: compare-and-clear wrap so out-of-range counts never occur
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcont <= '0;
      vcont <= '0;
    end else if (habilita) begin
      if (h_ultimo) begin
        hcont <= '0;
        if (v_ultimo) vcont <= '0;
        else          vcont <= vcont + 10'd1;
      end else begin
        hcont <= hcont + 10'd1;
      end
    end
  end

  // Zero-latency decode from the counter registers; only the end pulses see habilita
  always_comb begin
    x           = hcont;
    y           = vcont;
    video_ativo = (hcont < H_VIS) && (vcont < V_VIS);
    hsync       = !((hcont >= HS_INI) && (hcont < HS_FIM));
    vsync       = !((vcont >= VS_INI) && (vcont < VS_FIM));
    fim_linha   = habilita && h_ultimo;
    fim_quadro  = habilita && h_ultimo && v_ultimo;
  end

endmodule

// File: tb/tb_gerador_vga.sv
// Bench for gerador_vga: one instance at default 640x480 timing and one with a
// tiny raster so full-frame, vsync and end-of-frame behaviour fit in a short run.
module tb_gerador_vga;

  logic       clk;
  logic       rst_n;
  logic       habilita;

  logic [9:0] x_d, y_d;
  logic       va_d, hs_d, vs_d, fl_d, fq_d;
  logic [9:0] x_s, y_s;
  logic       va_s, hs_s, vs_s, fl_s, fq_s;

  int vectors    = 0;
  int miscompares = 0;

  // default-timing model position
  int mh = 0, mv = 0;
  // tiny-raster model position (15 x 9 total)
  int sh = 0, sv = 0;

  logic [49:0] sb[$];

  gerador_vga dut_d (
    .clk(clk), .rst_n(rst_n), .habilita(habilita),
    .x(x_d), .y(y_d), .video_ativo(va_d), .hsync(hs_d), .vsync(vs_d),
    .fim_linha(fl_d), .fim_quadro(fq_d)
  );

  gerador_vga #(
    .H_ATIVO(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ATIVO(5), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .habilita(habilita),
    .x(x_s), .y(y_s), .video_ativo(va_s), .hsync(hs_s), .vsync(vs_s),
    .fim_linha(fl_s), .fim_quadro(fq_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [24:0] exp_d(input int h, input int v, input logic en);
    logic va, hs, vs, fl, fq;
    va = (h < 640) && (v < 480);
    hs = !((h >= 656) && (h <= 751));
    vs = !((v >= 490) && (v <= 491));
    fl = en && (h == 799);
    fq = en && (h == 799) && (v == 524);
    return {10'(h), 10'(v), va, hs, vs, fl, fq};
  endfunction

  function automatic logic [24:0] exp_s(input int h, input int v, input logic en);
    logic va, hs, vs, fl, fq;
    va = (h < 8) && (v < 5);
    hs = !((h >= 10) && (h <= 12));
    vs = !((v >= 6) && (v <= 7));
    fl = en && (h == 14);
    fq = en && (h == 14) && (v == 8);
    return {10'(h), 10'(v), va, hs, vs, fl, fq};
  endfunction

  // One clock: drive inputs, queue expectations, compare, then advance the model
  task automatic step(input logic r, input logic en, input string tag);
    logic [49:0] e;
    logic [24:0] od, os;
    @(negedge clk);
    rst_n    = r;
    habilita = en;
    sb.push_back({exp_d(mh, mv, en), exp_s(sh, sv, en)});
    #1;
    e  = sb.pop_front();
    od = {x_d, y_d, va_d, hs_d, vs_d, fl_d, fq_d};
    os = {x_s, y_s, va_s, hs_s, vs_s, fl_s, fq_s};
    vectors++;
    assert (od === e[49:25]) else begin
      miscompares++;
      $error("FAIL %s default: observed %h expected %h (model x=%0d y=%0d)", tag, od, e[49:25], mh, mv);
    end
    vectors++;
    assert (os === e[24:0]) else begin
      miscompares++;
      $error("FAIL %s small: observed %h expected %h (model x=%0d y=%0d)", tag, os, e[24:0], sh, sv);
    end
    @(posedge clk);
    if (!r) begin
      mh = 0; mv = 0; sh = 0; sv = 0;
    end else if (en) begin
      if (mh == 799) begin
        mh = 0;
        mv = (mv == 524) ? 0 : mv + 1;
      end else mh = mh + 1;
      if (sh == 14) begin
        sh = 0;
        sv = (sv == 8) ? 0 : sv + 1;
      end else sh = sh + 1;
    end
  endtask

  initial begin
    int guard;
    rst_n    = 1'b0;
    habilita = 1'b0;
    repeat (2) @(posedge clk);

    // reset held with the enable high: reset must win
    step(1'b0, 1'b1, "reset_prio");
    step(1'b0, 1'b1, "reset_prio");
    // released but disabled: hold at zero
    step(1'b1, 1'b0, "post_reset_hold");
    step(1'b1, 1'b0, "post_reset_hold");

    // one full line plus a little: x 0..799, wrap, y 0->1, hsync/visible edges
    for (int i = 0; i < 810; i++) step(1'b1, 1'b1, "line_run");

    // half-rate pixel enable: every value held two clocks, no pulses when off
    for (int i = 0; i < 1700; i++) step(1'b1, (i % 2) == 0, "half_rate");

    // mid-line reset on the default raster
    guard = 0;
    while (mh != 300 && guard < 1000) begin
      step(1'b1, 1'b1, "seek_300");
      guard++;
    end
    vectors++;
    assert (mh == 300) else begin
      miscompares++;
      $error("FAIL seek_300 timeout: observed %0d expected %0d", mh, 300);
    end
    step(1'b0, 1'b1, "mid_reset");
    step(1'b1, 1'b1, "after_mid_reset");
    step(1'b1, 1'b1, "after_mid_reset");

    // full tiny frame, then reset coincident with the last pixel of the frame
    for (int i = 0; i < 140; i++) step(1'b1, 1'b1, "frame_run");
    guard = 0;
    while (!(sh == 14 && sv == 8) && guard < 200) begin
      step(1'b1, 1'b1, "seek_frame_end");
      guard++;
    end
    vectors++;
    assert (sh == 14 && sv == 8) else begin
      miscompares++;
      $error("FAIL seek_frame_end timeout: observed %0d,%0d expected 14,8", sh, sv);
    end
    step(1'b0, 1'b1, "reset_at_frame_end");
    step(1'b1, 1'b0, "masked_after_reset");
    step(1'b1, 1'b1, "resume");
    step(1'b1, 1'b1, "resume");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
